// File: rtl/multicycle_controller.sv
// Control FSM for a shared-resource multicycle RV32 datapath: sequences fetch, decode,
// execute, memory and writeback states and drives every select, strobe and ALU op.
module multicycle_controller #(
  parameter int DATA_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ResultSrc,
  output logic       instr_done,
  output logic       illegal_instr,
  output logic [3:0] state_o
);

  // Width only documents the datapath this controller is paired with.
  if (DATA_WIDTH < 1) begin : g_width_guard
  end

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t state_q, state_d;
  logic   f3_legal;
  logic [2:0] alu_op;

  assign f3_legal = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                    (funct3 == 3'b110) || (funct3 == 3'b111);

  // funct7_5 only selects SUB for register-register ops (op[5] set); addi ignores it.
  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000:  alu_op = (op[5] && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_op = ALU_SLT;
      3'b110:  alu_op = ALU_OR;
      3'b111:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = f3_legal ? S_EXECR : S_TRAP;
          7'b0010011:             state_d = f3_legal ? S_EXECI : S_TRAP;
          7'b1100011:             state_d = S_BEQ;
          7'b1101111:             state_d = S_JAL;
          default:                state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else if (en) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    mem_req       = 1'b0;
    MemWrite      = 1'b0;
    AdrSrc        = 1'b0;
    IRWrite       = 1'b0;
    PCWrite       = 1'b0;
    RegWrite      = 1'b0;
    ImmSrc        = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ALUControl    = ALU_ADD;
    ResultSrc     = 2'b00;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    state_o       = state_q;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = op[5] ? 2'b01 : 2'b00;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req    = 1'b1;
        MemWrite   = 1'b1;
        AdrSrc     = 1'b1;
        instr_done = mem_ready;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_op;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_op;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = zero;
        instr_done = 1'b1;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_TRAP:  illegal_instr = 1'b1;
      default: ;
    endcase
    // A frozen FSM must not repeat side effects; selects stay put so the datapath is stable.
    if (!en) begin
      mem_req    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
    end
    if (rst) begin
      mem_req       = 1'b0;
      MemWrite      = 1'b0;
      AdrSrc        = 1'b0;
      IRWrite       = 1'b0;
      PCWrite       = 1'b0;
      RegWrite      = 1'b0;
      ImmSrc        = 2'b00;
      ALUSrcA       = 2'b00;
      ALUSrcB       = 2'b00;
      ALUControl    = ALU_ADD;
      ResultSrc     = 2'b00;
      instr_done    = 1'b0;
      illegal_instr = 1'b0;
      state_o       = 4'd0;
    end
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style FSM that sequences the shared multicycle RV32 datapath: one ALU, one unified instruction/data memory port, register file and PC/IR/ALUOut/Data registers.
- Each instruction takes 3–5 states. The controller drives all mux selects, write strobes and ALUControl for those states.
- It handshakes the memory port with mem_req/mem_ready and flags unsupported opcodes.
- Supported instructions: lw, sw, R-type (add/sub/and/or/slt), addi-class I-type, beq, jal.

Parameters:
- DATA_WIDTH, 32, datapath width. Documentation only; no controller logic depends on it.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  advance enable; low freezes the FSM.
- op  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7_5  in  1  IR[30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the access this cycle.
- mem_req  out  1  memory access request.
- MemWrite  out  1  write qualifier for mem_req.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- IRWrite  out  1  load IR and OldPC.
- PCWrite  out  1  load PC from Result.
- RegWrite  out  1  register file write.
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rd1.
- ALUSrcB  out  2  ALU B select: 00 = rd2, 01 = imm, 10 = constant 4.
- ALUControl  out  3  ADD 000, SUB 001, AND 010, OR 011, SLT 101.
- ResultSrc  out  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_instr  out  1  high while in TRAP.
- state_o  out  4  current state, for debug.

Behaviour:
- Reset:
  - rst sampled high → state = FETCH (0) at that edge.
  - While rst is high, all outputs are forced to 0 combinationally.
  - Reset mid-instruction abandons the instruction; no strobe fires in the reset cycle.
- en low:
  - State holds.
  - mem_req, MemWrite, IRWrite, PCWrite, RegWrite and instr_done are forced to 0.
  - Selects keep their state values.
- Default values in every state: all strobes = 0, selects = 00, ALUControl = ADD.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10, TRAP 15.
- FETCH:
  - Outputs: mem_req = 1, AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ADD, ResultSrc = 10.
  - IRWrite = PCWrite = mem_ready.
  - Stay in FETCH until mem_ready, then go to DECODE.
- DECODE:
  - Outputs: ALUSrcA = 01, ALUSrcB = 01, ImmSrc = 10, ADD (precomputes the branch target into ALUOut).
  - Next state by op:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXECR.
    - 0010011 → EXECI.
    - 1100011 → BEQ.
    - 1101111 → JAL.
    - Any other op → TRAP.
  - R/I with funct3 not in {000, 010, 110, 111} → TRAP.
- MEMADR:
  - Outputs: ALUSrcA = 10, ALUSrcB = 01, ADD; ImmSrc = 00 for lw, 01 for sw.
  - Next state: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD:
  - Outputs: mem_req = 1, AdrSrc = 1, ResultSrc = 00.
  - Go to MEMWB on mem_ready, else stay.
- MEMWB: ResultSrc = 01, RegWrite = 1, instr_done = 1 → FETCH.
- MEMWRITE:
  - Outputs: mem_req = 1, MemWrite = 1, AdrSrc = 1, ResultSrc = 00.
  - On mem_ready: instr_done = 1, go to FETCH. Otherwise stay.
- EXECR: ALUSrcA = 10, ALUSrcB = 00, ALU-decode → ALUWB.
- EXECI: ALUSrcA = 10, ALUSrcB = 01, ImmSrc = 00, ALU-decode → ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1, instr_done = 1 → FETCH.
- BEQ:
  - Outputs: ALUSrcA = 10, ALUSrcB = 00, SUB, ResultSrc = 00.
  - PCWrite = zero; instr_done = 1.
  - → FETCH.
- JAL:
  - Outputs: ALUSrcA = 01, ALUSrcB = 10, ADD, ResultSrc = 00, PCWrite = 1 (PC ← target held in ALUOut).
  - → ALUWB (rd ← OldPC + 4).
- ALU-decode by funct3:
  - 000: SUB if op[5] & funct7_5, else ADD (addi ignores funct7_5).
  - 010: SLT. 110: OR. 111: AND.
- TRAP: illegal_instr = 1, all strobes 0; exit only through rst.
- Timing:
  - mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
  - Minimum latency with zero-wait memory: lw 5, sw 4, R/I 4, beq 3, jal 4 cycles.

Test Plan:
- Reset then addi (op 0010011, funct3 000), mem_ready = 1 → states 0,1,7,8,0. ALUControl = 000 in EXECI. RegWrite is high for exactly 1 cycle and instr_done pulses in ALUWB.
- R-type sub (funct3 000, funct7_5 = 1) then add (funct7_5 = 0) → ALUControl 001 then 000 in EXECR. Also check funct3 110 → 011 and 111 → 010.
- lw with mem_ready low for 3 cycles in both FETCH and MEMREAD → FETCH/MEMREAD stall 3 extra cycles each. IRWrite fires only on the ready cycle and RegWrite only in MEMWB; total 11 cycles.
- beq with zero = 1 then zero = 0 → PCWrite = 1 and 0 respectively in state 9. Both return to FETCH.
- op 1110011 → TRAP (15), illegal_instr held high for 10 cycles; rst → state 0 at the next edge and illegal_instr = 0.
- en low during MEMWRITE and rst asserted during EXECR:
  - en low in MEMWRITE → state held at 5, mem_req/MemWrite = 0; on en high, resumes and completes.
  - rst in EXECR → FETCH next cycle, no RegWrite pulse.
